// File: rtl/fir_serial_ctrl.sv
// Serial FIR sequencer: one signed MAC per tap, TAPS cycles per sample, plus coefficient file.
// Define FIR_SAT_EN to saturate dout to the signed OW range instead of two's-complement wrap.
module fir_serial_ctrl #(
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int TAPS = 8,
    parameter int OW   = 18
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [DW-1:0]           din,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]           coef_wdata,
    output logic                    coef_wr_err,
    output logic                    dout_valid,
    output logic [OW-1:0]           dout,
    output logic                    busy
);

    localparam int IW = $clog2(TAPS);
    localparam int PW = DW + CW;
    localparam int AW = PW + IW;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t               state_q, state_d;
    logic signed [DW-1:0] s_q [TAPS];
    logic signed [DW-1:0] s_d [TAPS];
    logic signed [CW-1:0] c_q [TAPS];
    logic signed [CW-1:0] c_d [TAPS];
    logic signed [AW-1:0] acc_q, acc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [OW-1:0]        dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 wr_err_q, wr_err_d;
    logic                 accept;
    logic                 coef_wr_ok;
    logic signed [DW-1:0] s_sel;
    logic signed [CW-1:0] c_sel;
    logic signed [PW-1:0] prod;
    logic [OW-1:0]        acc_out;

    assign s_sel = s_q[idx_q];
    assign c_sel = c_q[idx_q];
    // Both operands widened to PW so the product is full precision.
    assign prod  = $signed({{CW{s_sel[DW-1]}}, s_sel}) * $signed({{DW{c_sel[CW-1]}}, c_sel});

    assign coef_wr_ok = coef_we && (state_q == S_IDLE);
    assign wr_err_d   = coef_we && (state_q != S_IDLE);

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                assign s_d[gi] = accept ? din : s_q[gi];
            end else begin : g_body
                assign s_d[gi] = accept ? s_q[gi-1] : s_q[gi];
            end
            assign c_d[gi] = (coef_wr_ok && (coef_addr == IW'(gi))) ? coef_wdata : c_q[gi];
        end
    endgenerate

    generate
        if (OW >= AW) begin : g_out_ext
            assign acc_out = OW'(acc_q);
        end else begin : g_out_narrow
`ifdef FIR_SAT_EN
            localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
            assign acc_out = (acc_q > SAT_MAX) ? SAT_MAX[OW-1:0] :
                             (acc_q < SAT_MIN) ? SAT_MIN[OW-1:0] : acc_q[OW-1:0];
`else
            assign acc_out = acc_q[OW-1:0];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        accept       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    accept  = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + $signed({{IW{prod[PW-1]}}, prod});
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(TAPS - 1)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                dout_d       = acc_out;
                dout_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TAPS; i++) begin
                s_q[i] <= '0;
                c_q[i] <= '0;
            end
            acc_q        <= '0;
            idx_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            s_q          <= s_d;
            c_q          <= c_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign din_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign coef_wr_err = wr_err_q;

endmodule

// File: doc/fir_serial_ctrl.md
Name: fir_serial_ctrl

Overview:
Sequencing controller for the team's FIR filter. It time-multiplexes one signed multiply-accumulate across TAPS coefficients per input sample, so the FIR datapath does not need TAPS parallel multipliers. It owns the sample delay line and the coefficient register file, and accepts coefficient configuration writes. It sits between the sample source (the testbench memory reader, later the ADC front end) and the downstream consumer of dout.

Parameters:
DW, 8, input sample width, signed two's complement
CW, 8, coefficient width, signed two's complement
TAPS, 8, number of taps, power of two, >= 2
OW, 18, output width; the internal accumulator is AW = DW+CW+clog2(TAPS) bits (19 at defaults)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
din_valid  input  1  sample source has a sample on din
din_ready  output  1  controller can accept a sample
din  input  DW  input sample
coef_we  input  1  coefficient write strobe
coef_addr  input  clog2(TAPS)  coefficient index
coef_wdata  input  CW  coefficient value
coef_wr_err  output  1  one-cycle pulse: a write was dropped
dout_valid  output  1  one-cycle pulse: dout holds a new result
dout  output  OW  filter output
busy  output  1  high in MAC and OUT states

Behaviour:
- Reset, asynchronous on rstn low:
  - state=IDLE; delay line, coefficients, accumulator and tap index all zero.
  - dout=0, dout_valid=0, coef_wr_err=0, busy=0, din_ready=1 once rstn is released.
- FSM states IDLE, MAC, OUT:
  - IDLE: din_ready=1. When din_valid is high at a clock edge, the sample is accepted at that edge.
    - Delay line shifts: s[0]=din, s[k]=s[k-1]. acc=0, idx=0, next state MAC.
    - If din_valid is low, stay in IDLE.
  - MAC: on each edge, acc += s[idx]*c[idx] (full-precision signed, sign-extended to AW) and idx++.
    - After the edge where idx=TAPS-1 is processed, next state is OUT. MAC lasts exactly TAPS cycles.
  - OUT: on one edge, dout is registered from acc (see the optional feature) and dout_valid is set for that one cycle. Next state IDLE.
- Latency: accept at edge 0, dout/dout_valid updated at edge TAPS+1. Maximum throughput is one sample per TAPS+2 cycles.
- din_ready is low in MAC and OUT. din_valid in those states is ignored; the source must hold the sample until it is accepted.
- dout holds its value between pulses.
- Coefficient writes:
  - Accepted only in IDLE: c[coef_addr] <= coef_wdata.
  - A write while busy=1 is dropped, and coef_wr_err pulses high in the following cycle.
  - coef_we and a sample accept on the same IDLE edge: both take effect, and the new coefficient is used for that sample's computation.
- The tap index wraps naturally because TAPS is a power of two. idx is not used outside MAC.
- Reset during MAC or OUT: the computation is aborted, no dout_valid is produced, and all storage returns to reset values.

Optional Feature:
FIR_SAT_EN
- Defined: dout is acc saturated to the signed OW range, [-2^(OW-1), 2^(OW-1)-1].
- Undefined: dout = acc[OW-1:0], i.e. two's-complement wrap.
- If OW >= AW, both modes give the sign-extended acc.

Test Plan:
- Reset: hold rstn low, then release. Required: dout=0, dout_valid=0, busy=0, din_ready=1 on the first cycle after release.
- Impulse: write c[i]=i+1 for i=0..7, then feed din=1 followed by seven 0s with din_valid held high. Required: dout = 1,2,...,8, one dout_valid pulse every 10 cycles, first pulse at edge 9 after the first accept.
- Handshake: din_valid held high continuously. Required: din_ready high exactly 1 of every 10 cycles, and exactly one sample accepted per window with no duplicates.
- Busy write: coef_we to address 0 with 0x7F during MAC. Required: coef_wr_err pulses once, c[0] is unchanged, and the current and next results match the old coefficients.
- Overflow: all c=-128 and eight samples of -128 (acc=131072). Required: with FIR_SAT_EN, dout=131071; without it, dout=-131072 (0x20000).
- Mid-op reset: pull rstn low on the 4th MAC cycle, then release. Required: no dout_valid pulse, dout=0, and after one new sample with all coefficients 0, dout=0.
